ifetcher: RTL and testbench

Instruction fetch unit at the front of the pipeline. It keeps the program counter, fetches 32-bit instruction words from the memory controller, and delivers each word to the decoder as opcode plus remaining instruction bits over a valid/ready handshake. JAL targets are resolved locally; every other control transfer falls through to PC+4 until the back end issues a redirect.

---
 rtl/ifetcher.sv | 143 ++++++++++++++
 tb/tb_ifetcher.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetcher.sv
// Instruction fetch unit: owns the PC, requests words from the memory controller,
// resolves JAL locally and hands each word to the decoder over a valid/ready handshake.
module ifetcher #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    output logic                  IF2MC_en,
    output logic [ADDR_WIDTH-1:0] IF2MC_addr,
    input  logic                  MC2IF_en,
    input  logic [31:0]           MC2IF_inst,
    output logic                  IF2DC_en,
    output logic [ADDR_WIDTH-1:0] IF2DC_pc,
    output logic [6:0]            IF2DC_opcode,
    output logic [31:7]           IF2DC_exop,
    input  logic                  DC2IF_query_inst,
    input  logic                  RB2IF_jump_en,
    input  logic [ADDR_WIDTH-1:0] RB2IF_jump_addr
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        HOLD     = 2'd2,
        DROP     = 2'd3
    } state_t;

    localparam logic [6:0] OPC_JAL = 7'b1101111;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic                    mc_en_q, mc_en_d;
    logic [ADDR_WIDTH-1:0]   mc_addr_q, mc_addr_d;
    logic                    dc_en_q, dc_en_d;
    logic [ADDR_WIDTH-1:0]   dc_pc_q, dc_pc_d;
    logic [6:0]              dc_opcode_q, dc_opcode_d;
    logic [31:7]             dc_exop_q, dc_exop_d;

    logic [20:0]             jal_off;
    logic [ADDR_WIDTH-1:0]   next_pc;

    // J-type immediate, sign-extended to the address width; sums wrap silently.
    assign jal_off = {MC2IF_inst[31], MC2IF_inst[19:12], MC2IF_inst[20], MC2IF_inst[30:21], 1'b0};
    assign next_pc = (MC2IF_inst[6:0] == OPC_JAL)
                   ? pc_q + ADDR_WIDTH'(signed'(jal_off))
                   : pc_q + ADDR_WIDTH'(4);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        mc_en_d     = mc_en_q;
        mc_addr_d   = mc_addr_q;
        dc_en_d     = dc_en_q;
        dc_pc_d     = dc_pc_q;
        dc_opcode_d = dc_opcode_q;
        dc_exop_d   = dc_exop_q;

        if (rdy_in) begin
            if (RB2IF_jump_en) begin
                pc_d = RB2IF_jump_addr;
                unique case (state_q)
                    IDLE: ;
                    HOLD: begin
                        dc_en_d = 1'b0;
                        state_d = IDLE;
                    end
                    // An in-flight request cannot be cancelled; drain it in DROP.
                    WAIT_MEM: begin
                        mc_en_d = 1'b0;
                        state_d = MC2IF_en ? IDLE : DROP;
                    end
                    DROP: begin
                        if (MC2IF_en) state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end else begin
                unique case (state_q)
                    IDLE: begin
                        mc_en_d   = 1'b1;
                        mc_addr_d = pc_q;
                        state_d   = WAIT_MEM;
                    end
                    WAIT_MEM: begin
                        if (MC2IF_en) begin
                            mc_en_d     = 1'b0;
                            dc_en_d     = 1'b1;
                            dc_pc_d     = pc_q;
                            dc_opcode_d = MC2IF_inst[6:0];
                            dc_exop_d   = MC2IF_inst[31:7];
                            pc_d        = next_pc;
                            state_d     = HOLD;
                        end
                    end
                    HOLD: begin
                        if (DC2IF_query_inst) begin
                            dc_en_d   = 1'b0;
                            mc_en_d   = 1'b1;
                            mc_addr_d = pc_q;
                            state_d   = WAIT_MEM;
                        end
                    end
                    DROP: begin
                        if (MC2IF_en) state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            pc_q        <= RESET_ADDR;
            mc_en_q     <= 1'b0;
            mc_addr_q   <= '0;
            dc_en_q     <= 1'b0;
            dc_pc_q     <= '0;
            dc_opcode_q <= '0;
            dc_exop_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mc_en_q     <= mc_en_d;
            mc_addr_q   <= mc_addr_d;
            dc_en_q     <= dc_en_d;
            dc_pc_q     <= dc_pc_d;
            dc_opcode_q <= dc_opcode_d;
            dc_exop_q   <= dc_exop_d;
        end
    end

    assign IF2MC_en     = mc_en_q;
    assign IF2MC_addr   = mc_addr_q;
    assign IF2DC_en     = dc_en_q;
    assign IF2DC_pc     = dc_pc_q;
    assign IF2DC_opcode = dc_opcode_q;
    assign IF2DC_exop   = dc_exop_q;

endmodule

// File: tb/tb_ifetcher.sv
// Bench for ifetcher: behavioural memory with programmable latency, scoreboards
// of expected fetch addresses and expected deliveries.
module tb_ifetcher;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        IF2MC_en;
    logic [31:0] IF2MC_addr;
    logic        MC2IF_en;
    logic [31:0] MC2IF_inst;
    logic        IF2DC_en;
    logic [31:0] IF2DC_pc;
    logic [6:0]  IF2DC_opcode;
    logic [31:7] IF2DC_exop;
    logic        DC2IF_query_inst;
    logic        RB2IF_jump_en;
    logic [31:0] RB2IF_jump_addr;

    always #5 clk_in = ~clk_in;

    ifetcher #(.ADDR_WIDTH(32), .RESET_ADDR(32'h0)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .IF2MC_en         (IF2MC_en),
        .IF2MC_addr       (IF2MC_addr),
        .MC2IF_en         (MC2IF_en),
        .MC2IF_inst       (MC2IF_inst),
        .IF2DC_en         (IF2DC_en),
        .IF2DC_pc         (IF2DC_pc),
        .IF2DC_opcode     (IF2DC_opcode),
        .IF2DC_exop       (IF2DC_exop),
        .DC2IF_query_inst (DC2IF_query_inst),
        .RB2IF_jump_en    (RB2IF_jump_en),
        .RB2IF_jump_addr  (RB2IF_jump_addr)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } dlv_t;

    logic [31:0] req_q[$];
    dlv_t        dlv_q[$];

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          dlv_cnt = 0;
    int          last_dlv_cyc = 0;
    int          lat = 1;
    int          cnt = 0;
    bit          busy = 1'b0;
    bit          dc_prev = 1'b0;
    bit          check_rate = 1'b0;
    logic [31:0] lat_addr = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Program image: two JALs, ADDI x1,x1,imm=addr everywhere else.
    function automatic logic [31:0] prog(input logic [31:0] a);
        logic [31:0] w;
        case (a)
            32'h10:  w = 32'h0100006F;
            32'h20:  w = 32'hFF9FF06F;
            default: w = {a[11:0], 5'd1, 3'd0, 5'd1, 7'h13};
        endcase
        return w;
    endfunction

    task automatic push_req(input logic [31:0] a);
        req_q.push_back(a);
    endtask

    task automatic push_step(input logic [31:0] a);
        dlv_t d;
        d.pc   = a;
        d.inst = prog(a);
        req_q.push_back(a);
        dlv_q.push_back(d);
    endtask

    // One cycle: sample at the falling edge, play memory, score requests and deliveries.
    task automatic tick();
        dlv_t d;
        @(negedge clk_in);
        cyc++;
        if (!rdy_in) return;

        if (MC2IF_en) begin
            MC2IF_en = 1'b0;
            busy     = 1'b0;
        end else if (busy) begin
            if (IF2MC_en) check_eq("req_addr_hold", IF2MC_addr, lat_addr);
            cnt--;
            if (cnt <= 0) begin
                MC2IF_en   = 1'b1;
                MC2IF_inst = prog(lat_addr);
            end
        end else if (IF2MC_en) begin
            check_eq("req_expected", 32'(req_q.size() != 0), 32'd1);
            if (req_q.size() != 0) check_eq("req_addr", IF2MC_addr, req_q.pop_front());
            $display("req  cyc=%0d addr=%h", cyc, IF2MC_addr);
            lat_addr = IF2MC_addr;
            busy     = 1'b1;
            cnt      = lat - 1;
            if (cnt <= 0) begin
                MC2IF_en   = 1'b1;
                MC2IF_inst = prog(lat_addr);
            end
        end

        if (IF2DC_en && !dc_prev) begin
            $display("dlv  cyc=%0d pc=%h opcode=%h exop=%h", cyc, IF2DC_pc, IF2DC_opcode, IF2DC_exop);
            check_eq("dlv_expected", 32'(dlv_q.size() != 0), 32'd1);
            if (dlv_q.size() != 0) begin
                d = dlv_q.pop_front();
                check_eq("dlv_pc", IF2DC_pc, d.pc);
                check_eq("dlv_opcode", 32'(IF2DC_opcode), 32'(d.inst[6:0]));
                check_eq("dlv_exop", 32'(IF2DC_exop), 32'(d.inst[31:7]));
            end
            if (check_rate && dlv_cnt > 0) check_eq("dlv_rate", 32'(cyc - last_dlv_cyc), 32'd2);
            last_dlv_cyc = cyc;
            dlv_cnt++;
        end
        dc_prev = IF2DC_en;
    endtask

    task automatic run_until(input int target);
        for (int i = 0; i < 300 && dlv_cnt < target; i++) tick();
        check_eq("dlv_count", 32'(dlv_cnt), 32'(target));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_mc_en"}, 32'(IF2MC_en), 32'd0);
        check_eq({tag, "_mc_addr"}, IF2MC_addr, 32'd0);
        check_eq({tag, "_dc_en"}, 32'(IF2DC_en), 32'd0);
        check_eq({tag, "_dc_pc"}, IF2DC_pc, 32'd0);
        check_eq({tag, "_dc_opcode"}, 32'(IF2DC_opcode), 32'd0);
        check_eq({tag, "_dc_exop"}, 32'(IF2DC_exop), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_in           = 1'b0;
        rdy_in           = 1'b1;
        MC2IF_en         = 1'b0;
        MC2IF_inst       = '0;
        DC2IF_query_inst = 1'b0;
        RB2IF_jump_en    = 1'b0;
        RB2IF_jump_addr  = '0;

        repeat (2) @(negedge clk_in);
        check_reset_outputs("rst");

        // Streaming at N=1, query held high: 0, 4, 8 every two cycles.
        push_step(32'h0);
        push_step(32'h4);
        push_step(32'h8);
        rst_in           = 1'b1;
        DC2IF_query_inst = 1'b1;
        check_rate       = 1'b1;
        tick();
        check_eq("first_req", 32'(IF2MC_en), 32'd1);
        run_until(3);
        DC2IF_query_inst = 1'b0;
        check_rate       = 1'b0;

        // Backpressure: payload held, no new request.
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_dc_en", 32'(IF2DC_en), 32'd1);
            check_eq("bp_dc_pc", IF2DC_pc, 32'h8);
            check_eq("bp_opcode", 32'(IF2DC_opcode), 32'h13);
            check_eq("bp_mc_en", 32'(IF2MC_en), 32'd0);
        end

        // Sequential word, then JAL +16 at 0x10 and JAL -8 at 0x20.
        push_step(32'hC);
        push_step(32'h10);
        push_step(32'h20);
        push_step(32'h18);
        DC2IF_query_inst = 1'b1;
        run_until(7);
        DC2IF_query_inst = 1'b0;

        // Pause in HOLD: everything frozen even with query high.
        rdy_in           = 1'b0;
        DC2IF_query_inst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("pause_dc_en", 32'(IF2DC_en), 32'd1);
            check_eq("pause_dc_pc", IF2DC_pc, 32'h18);
            check_eq("pause_exop", 32'(IF2DC_exop), 32'(prog(32'h18) >> 7));
            check_eq("pause_mc_en", 32'(IF2MC_en), 32'd0);
        end

        // Redirect in HOLD with query high: instruction flushed, fetch at target.
        rdy_in          = 1'b1;
        RB2IF_jump_en   = 1'b1;
        RB2IF_jump_addr = 32'h100;
        push_step(32'h100);
        tick();
        RB2IF_jump_en = 1'b0;
        check_eq("redir_hold_dc_en", 32'(IF2DC_en), 32'd0);
        check_eq("redir_hold_mc_en", 32'(IF2MC_en), 32'd0);
        tick();
        check_eq("redir_hold_req", 32'(IF2MC_en), 32'd1);
        run_until(8);
        DC2IF_query_inst = 1'b0;

        // Redirect in WAIT_MEM with N=4: late response swallowed.
        lat = 4;
        push_req(32'h104);
        DC2IF_query_inst = 1'b1;
        tick();
        DC2IF_query_inst = 1'b0;
        check_eq("wm_req", 32'(IF2MC_en), 32'd1);
        tick();
        RB2IF_jump_en   = 1'b1;
        RB2IF_jump_addr = 32'h200;
        tick();
        RB2IF_jump_en = 1'b0;
        check_eq("drop_mc_en", 32'(IF2MC_en), 32'd0);
        check_eq("drop_dc_en", 32'(IF2DC_en), 32'd0);
        push_step(32'h200);
        run_until(9);

        // Asynchronous reset in the middle of a fetch.
        push_req(32'h204);
        DC2IF_query_inst = 1'b1;
        tick();
        DC2IF_query_inst = 1'b0;
        check_eq("ar_req", 32'(IF2MC_en), 32'd1);
        tick();
        #2 rst_in = 1'b0;
        #1 check_reset_outputs("async_rst");
        busy     = 1'b0;
        MC2IF_en = 1'b0;
        dc_prev  = 1'b0;
        push_step(32'h0);
        @(negedge clk_in);
        rst_in = 1'b1;
        tick();
        check_eq("restart_req", 32'(IF2MC_en), 32'd1);
        run_until(10);

        check_eq("req_q_left", 32'(req_q.size()), 32'd0);
        check_eq("dlv_q_left", 32'(dlv_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
